uart_i2c_cmd_bridge: RTL and testbench
======================================

// Module: uart_i2c_cmd_bridge
// PURPOSE
//  Bridges a UART byte stream to an AXI-stream I2C master (command + data channels).
//  Host sends 2 bytes: byte1 = {i2c_addr[6:0], rw}, byte2 = write data (rw=0) or {flag, count[6:0]} (rw=1).
//  Block runs the I2C transaction, returns read data + one status byte over UART, pulses INT_Pin when done.
//  Sits between uart (rx/tx AXI-stream) and i2c_master.
// PARAMETERS
//  none (addr 7 bit, data 8 bit fixed)
// PORTS
//  clk                  in   1  system clock
//  rstn                 in   1  reset: one clock; reset is synchronous and active-low
//  m_tdata              in   8  UART rx byte
//  m_tvalid             in   1  UART rx byte valid
//  m_tready             out  1  accept UART rx byte
//  s_tdata              out  8  byte to UART tx
//  s_tvalid             out  1  UART tx valid
//  s_tready             in   1  UART tx ready
//  tx_busy              in   1  UART transmitter busy (status only)
//  rx_busy              in   1  UART receiver busy (status only)
//  rx_overrun_error     in   1  UART rx overrun
//  rx_frame_error       in   1  UART rx frame error
//  s_cmd_Addr           out  7  I2C target address
//  s_cmd_start/read/write/write_multiple/stop  out 1 each  I2C command flags
//  s_cmd_valid          out  1  command valid
//  s_cmd_ready          in   1  command ready (also = master idle after last command)
//  s_cmd_tdata          out  8  I2C write data
//  s_cmd_tvalid/tlast   out  1  write data valid / last
//  s_cmd_tready         in   1  write data ready
//  m_cmd_tdata          in   8  I2C read data
//  m_cmd_tvalid/tlast   in   1  read data valid / last
//  m_cmd_tready         out  1  read data ready
//  missed_ack           in   1  I2C NACK pulse
//  INT_Pin              out  1  1-cycle done pulse
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): all outputs 0, state IDLE, error flag 0; aborts any transaction, no status sent.
//  FSM: GET_ADDR -> GET_B2 -> {WR_CMD -> WR_DATA | RD_CMD -> RD_DATA -> RD_TX (loop)} -> WAIT_IDLE -> TX_STAT -> DONE -> GET_ADDR.
//  GET_ADDR/GET_B2: m_tready=1; byte latched on m_tvalid&m_tready. rx_overrun_error or rx_frame_error
//   in these states drops partial frame -> GET_ADDR. m_tready=0 in all other states (bytes ignored).
//  All valid outputs held with stable payload until their ready; accept = valid&ready same edge.
//  WR_CMD (rw=0): s_cmd_Addr=byte1[7:1], start=1, write_multiple=1, stop=1, read=write=0 until accepted.
//  WR_DATA: s_cmd_tdata=byte2 verbatim, tvalid=1, tlast=1 until s_cmd_tready.
//  RD (rw=1): N=byte2[6:0] (0 treated as 1); byte2[7] ignored. For i=0..N-1: command read=1,
//   start=(i==0), stop=(i==N-1); then m_cmd_tready=1 until m_cmd_tvalid; captured byte sent on
//   s_tdata (wait s_tready) before next command. m_cmd_tlast ignored.
//  missed_ack seen in any transaction state sets error flag; read loop aborts (no further cmds/bytes).
//  WAIT_IDLE: wait s_cmd_ready=1 (master finished stop).
//  TX_STAT: s_tdata=8'h00 if no error, 8'hFF if error; wait s_tready.
//  DONE: INT_Pin=1 exactly one cycle, clear error flag, -> GET_ADDR.
//  tx_busy/rx_busy do not gate flow; handshake uses s_tready/m_tvalid only.
// TESTING
//  Write: UART 0x9A,0xBB -> cmd addr 0x4D start/write_multiple/stop, data 0xBB tlast=1, UART 0x00, INT 1 cycle.
//  Read: UART 0x9B,0x83; slave returns 0x11,0x22,0x33 -> 3 read cmds (start on 1st, stop on 3rd), UART 0x11,0x22,0x33,0x00.
//  NACK: write with missed_ack pulse after cmd accept -> UART status 0xFF, INT pulse, next frame 0x00 status.
//  Read count 0: UART 0x9B,0x00 -> one read cmd with start=1 stop=1, 1 data byte + 0x00.
//  Frame error after byte1 -> no I2C cmd; following 0x9A,0x55 runs normal write.
//  rstn=0 during RD_DATA -> all outputs 0 next edge; new write frame after release completes normally.

Source files
------------

// File: rtl/uart_i2c_cmd_bridge.sv
// UART-to-I2C command bridge: takes a two-byte host frame from the UART rx
// stream, issues the matching I2C master command/data transfers, returns any
// read bytes plus a status byte on the UART tx stream, and pulses INT_Pin.
module uart_i2c_cmd_bridge (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] m_tdata,
  input  logic       m_tvalid,
  output logic       m_tready,
  output logic [7:0] s_tdata,
  output logic       s_tvalid,
  input  logic       s_tready,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       rx_overrun_error,
  input  logic       rx_frame_error,
  output logic [6:0] s_cmd_Addr,
  output logic       s_cmd_start,
  output logic       s_cmd_read,
  output logic       s_cmd_write,
  output logic       s_cmd_write_multiple,
  output logic       s_cmd_stop,
  output logic       s_cmd_valid,
  input  logic       s_cmd_ready,
  output logic [7:0] s_cmd_tdata,
  output logic       s_cmd_tvalid,
  output logic       s_cmd_tlast,
  input  logic       s_cmd_tready,
  input  logic [7:0] m_cmd_tdata,
  input  logic       m_cmd_tvalid,
  input  logic       m_cmd_tlast,
  output logic       m_cmd_tready,
  input  logic       missed_ack,
  output logic       INT_Pin
);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_B2, WR_CMD, WR_DATA, RD_CMD, RD_DATA, RD_TX,
    WAIT_IDLE, TX_STAT, DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] byte1, byte2, rd_byte;
  logic [6:0] rd_idx, rd_num;
  logic       err, err_now, rx_err, rd_last, in_txn;

  // Status-only UART flags and the I2C tlast are informational here.
  logic unused_inputs;
  assign unused_inputs = ^{tx_busy, rx_busy, m_cmd_tlast};

  assign rx_err  = rx_overrun_error | rx_frame_error;
  assign err_now = err | missed_ack;
  assign rd_num  = (byte2[6:0] == 7'd0) ? 7'd1 : byte2[6:0];
  assign rd_last = (rd_idx == rd_num - 7'd1);
  assign in_txn  = (state == WR_CMD) || (state == WR_DATA) || (state == RD_CMD) ||
                   (state == RD_DATA) || (state == RD_TX) || (state == WAIT_IDLE);

  // State register plus frame bytes, read counter, captured read byte, error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      byte1   <= '0;
      byte2   <= '0;
      rd_byte <= '0;
      rd_idx  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == GET_ADDR && m_tvalid && !rx_err) byte1 <= m_tdata;
      if (state == GET_B2 && m_tvalid && !rx_err) begin
        byte2  <= m_tdata;
        rd_idx <= '0;
      end
      if (state == RD_DATA && m_cmd_tvalid) rd_byte <= m_cmd_tdata;
      if (state == RD_TX && s_tready) rd_idx <= rd_idx + 7'd1;
      if (state == DONE) err <= 1'b0;
      else if (in_txn && missed_ack) err <= 1'b1;
    end
  end

  // Next-state and per-state output decode; every output idles at 0.
  always_comb begin
    state_next           = state;
    m_tready             = 1'b0;
    s_tdata              = '0;
    s_tvalid             = 1'b0;
    s_cmd_Addr           = '0;
    s_cmd_start          = 1'b0;
    s_cmd_read           = 1'b0;
    s_cmd_write          = 1'b0;
    s_cmd_write_multiple = 1'b0;
    s_cmd_stop           = 1'b0;
    s_cmd_valid          = 1'b0;
    s_cmd_tdata          = '0;
    s_cmd_tvalid         = 1'b0;
    s_cmd_tlast          = 1'b0;
    m_cmd_tready         = 1'b0;
    INT_Pin              = 1'b0;
    case (state)
      IDLE: state_next = GET_ADDR;
      GET_ADDR: begin
        m_tready = 1'b1;
        if (!rx_err && m_tvalid) state_next = GET_B2;
      end
      GET_B2: begin
        m_tready = 1'b1;
        if (rx_err) state_next = GET_ADDR;
        else if (m_tvalid) state_next = byte1[0] ? RD_CMD : WR_CMD;
      end
      WR_CMD: begin
        s_cmd_Addr           = byte1[7:1];
        s_cmd_start          = 1'b1;
        s_cmd_write_multiple = 1'b1;
        s_cmd_stop           = 1'b1;
        s_cmd_valid          = 1'b1;
        if (s_cmd_ready) state_next = WR_DATA;
      end
      WR_DATA: begin
        s_cmd_tdata  = byte2;
        s_cmd_tvalid = 1'b1;
        s_cmd_tlast  = 1'b1;
        if (s_cmd_tready) state_next = WAIT_IDLE;
      end
      RD_CMD: begin
        s_cmd_Addr  = byte1[7:1];
        s_cmd_read  = 1'b1;
        s_cmd_start = (rd_idx == 7'd0);
        s_cmd_stop  = rd_last;
        s_cmd_valid = 1'b1;
        // A NACK abandons the read loop only once the command in flight is taken.
        if (s_cmd_ready) state_next = err_now ? WAIT_IDLE : RD_DATA;
      end
      RD_DATA: begin
        m_cmd_tready = 1'b1;
        if (missed_ack) state_next = WAIT_IDLE;
        else if (m_cmd_tvalid) state_next = RD_TX;
      end
      RD_TX: begin
        s_tdata  = rd_byte;
        s_tvalid = 1'b1;
        if (s_tready) state_next = (err_now || rd_last) ? WAIT_IDLE : RD_CMD;
      end
      WAIT_IDLE: if (s_cmd_ready) state_next = TX_STAT;
      TX_STAT: begin
        s_tdata  = err ? 8'hFF : 8'h00;
        s_tvalid = 1'b1;
        if (s_tready) state_next = DONE;
      end
      DONE: begin
        INT_Pin    = 1'b1;
        state_next = GET_ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_i2c_cmd_bridge.sv
// Directed self-checking bench for uart_i2c_cmd_bridge.
module tb_uart_i2c_cmd_bridge;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready;
  logic       tx_busy, rx_busy, rx_overrun_error, rx_frame_error;
  logic [6:0] s_cmd_Addr;
  logic       s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop;
  logic       s_cmd_valid, s_cmd_ready;
  logic [7:0] s_cmd_tdata;
  logic       s_cmd_tvalid, s_cmd_tlast, s_cmd_tready;
  logic [7:0] m_cmd_tdata;
  logic       m_cmd_tvalid, m_cmd_tlast, m_cmd_tready;
  logic       missed_ack, INT_Pin;

  int n_checks = 0;
  int n_fail   = 0;
  int cmd_count = 0;
  int c0;

  always #5 clk = ~clk;

  uart_i2c_cmd_bridge dut (
    .clk(clk), .rstn(rstn),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
    .s_cmd_Addr(s_cmd_Addr), .s_cmd_start(s_cmd_start), .s_cmd_read(s_cmd_read),
    .s_cmd_write(s_cmd_write), .s_cmd_write_multiple(s_cmd_write_multiple),
    .s_cmd_stop(s_cmd_stop), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tlast(s_cmd_tlast),
    .s_cmd_tready(s_cmd_tready),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tlast(m_cmd_tlast),
    .m_cmd_tready(m_cmd_tready),
    .missed_ack(missed_ack), .INT_Pin(INT_Pin)
  );

  // Count accepted I2C commands.
  always @(posedge clk) if (rstn && s_cmd_valid && s_cmd_ready) cmd_count <= cmd_count + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {m_tready, s_tdata, s_tvalid, s_cmd_Addr, s_cmd_start, s_cmd_read, s_cmd_write,
            s_cmd_write_multiple, s_cmd_stop, s_cmd_valid, s_cmd_tdata, s_cmd_tvalid,
            s_cmd_tlast, m_cmd_tready, INT_Pin};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic send_byte(input string tag, input logic [7:0] b);
    int n = 0;
    m_tdata = b; m_tvalid = 1'b1;
    while (!m_tready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_rx_accept"}, m_tready, 1'b1);
    @(negedge clk);
    m_tvalid = 1'b0;
  endtask

  task automatic wait_cmd(input string tag, input logic [6:0] a,
                          input logic st, input logic rd, input logic wm, input logic sp);
    int n = 0;
    while (!s_cmd_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_seen"}, s_cmd_valid, 1'b1);
    check(tag, {s_cmd_Addr, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop},
          {a, st, rd, 1'b0, wm, sp});
    @(negedge clk);
  endtask

  task automatic wait_wdata(input string tag, input logic [7:0] d);
    int n = 0;
    while (!s_cmd_tvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_seen"}, s_cmd_tvalid, 1'b1);
    check(tag, {s_cmd_tdata, s_cmd_tlast}, {d, 1'b1});
    @(negedge clk);
  endtask

  task automatic supply_rd(input string tag, input logic [7:0] d);
    int n = 0;
    while (!m_cmd_tready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_req"}, m_cmd_tready, 1'b1);
    m_cmd_tdata = d; m_cmd_tvalid = 1'b1; m_cmd_tlast = 1'b0;
    @(negedge clk);
    m_cmd_tvalid = 1'b0;
  endtask

  task automatic wait_uart(input string tag, input logic [7:0] d);
    int n = 0;
    while (!s_tvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_seen"}, s_tvalid, 1'b1);
    check(tag, s_tdata, d);
    @(negedge clk);
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (!INT_Pin && n < 50) begin @(negedge clk); n++; end
    check({tag, "_int"}, INT_Pin, 1'b1);
    @(negedge clk);
    check({tag, "_int_width"}, INT_Pin, 1'b0);
  endtask

  task automatic write_frame(input string tag, input logic [7:0] d, input logic [7:0] stat);
    c0 = cmd_count;
    send_byte(tag, 8'h9A);
    send_byte(tag, d);
    wait_cmd({tag, "_cmd"}, 7'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_wdata({tag, "_data"}, d);
    wait_uart({tag, "_stat"}, stat);
    wait_int(tag);
    check({tag, "_ncmd"}, cmd_count - c0, 1);
  endtask

  initial begin
    rstn = 1'b0; m_tdata = '0; m_tvalid = 1'b0; s_tready = 1'b1;
    tx_busy = 1'b0; rx_busy = 1'b0; rx_overrun_error = 1'b0; rx_frame_error = 1'b0;
    s_cmd_ready = 1'b1; s_cmd_tready = 1'b1;
    m_cmd_tdata = '0; m_cmd_tvalid = 1'b0; m_cmd_tlast = 1'b0; missed_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Write with status held while tx not ready.
    c0 = cmd_count;
    send_byte("wr", 8'h9A);
    send_byte("wr", 8'hBB);
    wait_cmd("wr_cmd", 7'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    s_tready = 1'b0;
    wait_wdata("wr_data", 8'hBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_stat_hold", {s_tvalid, s_tdata}, {1'b1, 8'h00});
    end
    s_tready = 1'b1;
    wait_uart("wr_stat", 8'h00);
    wait_int("wr");
    check("wr_ncmd", cmd_count - c0, 1);

    // Three-byte read.
    c0 = cmd_count;
    send_byte("rd", 8'h9B);
    send_byte("rd", 8'h83);
    wait_cmd("rd_cmd0", 7'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
    supply_rd("rd0", 8'h11);
    wait_uart("rd_byte0", 8'h11);
    wait_cmd("rd_cmd1", 7'h4D, 1'b0, 1'b1, 1'b0, 1'b0);
    supply_rd("rd1", 8'h22);
    wait_uart("rd_byte1", 8'h22);
    wait_cmd("rd_cmd2", 7'h4D, 1'b0, 1'b1, 1'b0, 1'b1);
    supply_rd("rd2", 8'h33);
    wait_uart("rd_byte2", 8'h33);
    wait_uart("rd_stat", 8'h00);
    wait_int("rd");
    check("rd_ncmd", cmd_count - c0, 3);

    // NACK on write, then error flag cleared for the next frame.
    send_byte("nack", 8'h9A);
    send_byte("nack", 8'h12);
    wait_cmd("nack_cmd", 7'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    missed_ack = 1'b1;
    wait_wdata("nack_data", 8'h12);
    missed_ack = 1'b0;
    wait_uart("nack_stat", 8'hFF);
    wait_int("nack");
    write_frame("after_nack", 8'h34, 8'h00);

    // Read count 0 behaves as a single read.
    c0 = cmd_count;
    send_byte("rd0cnt", 8'h9B);
    send_byte("rd0cnt", 8'h00);
    wait_cmd("rd0cnt_cmd", 7'h4D, 1'b1, 1'b1, 1'b0, 1'b1);
    supply_rd("rd0cnt", 8'hA5);
    wait_uart("rd0cnt_byte", 8'hA5);
    wait_uart("rd0cnt_stat", 8'h00);
    wait_int("rd0cnt");
    check("rd0cnt_ncmd", cmd_count - c0, 1);

    // Frame error after byte1 drops the partial frame.
    c0 = cmd_count;
    send_byte("ferr", 8'h9A);
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_frame_error = 1'b0;
    repeat (5) @(negedge clk);
    check("ferr_no_cmd", cmd_count - c0, 0);
    write_frame("after_ferr", 8'h55, 8'h00);

    // Reset in the middle of a read.
    send_byte("rst", 8'h9B);
    send_byte("rst", 8'h02);
    wait_cmd("rst_cmd", 7'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!m_cmd_tready && n < 50) begin @(negedge clk); n++; end
    end
    check("rst_in_rd_data", m_cmd_tready, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_outs", all_outs(), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    write_frame("after_rst", 8'h77, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
